// File: rtl/fifo_sync_buf.sv
// -----------------------------------------------------------------------------
// fifo_sync_buf
//  Single-clock FIFO with on-chip storage. Used as the generic buffer between
//  producers and consumers running in the same clock domain.
//
//  Handshake: a write is accepted (wr_acc) when wrreq is high and the FIFO is
//  not full, or when it is full but a pop is accepted in the same cycle. A pop
//  is accepted (rd_acc) when rdack is high and the FIFO is not empty. Requests
//  that are not accepted are dropped and reported one cycle later on
//  overrun/underrun. There is no empty-bypass: writing and popping an empty
//  FIFO in one cycle stores the word and flags an underrun.
//
//  Ports:
//   clk           in   clock, all state on rising edge
//   n_reset       in   asynchronous active-low reset
//   flush         in   synchronous clear of contents (wins over wrreq/rdack)
//   wrreq         in   write request
//   wdata         in   write data, sampled when the write is accepted
//   rdack         in   read acknowledge / pop request
//   rdata         out  read data
//   rvalid        out  rdata valid
//   empty         out  level == 0
//   full          out  level == DEPTH
//   almost_empty  out  level <= AEMPTY
//   almost_full   out  level >= AFULL
//   underrun      out  1-cycle pulse: pop refused in previous cycle
//   overrun       out  1-cycle pulse: write refused in previous cycle
//   level         out  word count, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_sync_buf #(
   parameter int DATA_W  = 8,
   parameter int DEPTH_N = 4,
   parameter int AFULL   = (2**DEPTH_N) - 2,
   parameter int AEMPTY  = 1,
   parameter bit FWFT    = 1'b1
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               flush,
   input  logic               wrreq,
   input  logic [DATA_W-1:0]  wdata,
   input  logic               rdack,
   output logic [DATA_W-1:0]  rdata,
   output logic               rvalid,
   output logic               empty,
   output logic               full,
   output logic               almost_empty,
   output logic               almost_full,
   output logic               underrun,
   output logic               overrun,
   output logic [DEPTH_N:0]   level
);

   localparam int DEPTH = 2**DEPTH_N;
   localparam int LVL_W = DEPTH_N + 1;

   localparam logic [LVL_W-1:0] C_DEPTH  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] C_AFULL  = LVL_W'(AFULL);
   localparam logic [LVL_W-1:0] C_AEMPTY = LVL_W'(AEMPTY);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [DEPTH_N-1:0] r_head;
   logic [DEPTH_N-1:0] r_tail;
   logic [LVL_W-1:0]   r_level;
   logic               r_underrun;
   logic               r_overrun;

   logic               w_empty;
   logic               w_full;
   logic               w_rd_acc;
   logic               w_wr_acc;

   // Flags decode straight from the registered level.
   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == C_DEPTH);

   // Flush suppresses both accepts, so nothing moves in a flush cycle.
   assign w_rd_acc = rdack & ~w_empty & ~flush;
   // Writing while full is legal only because the same-cycle pop frees the
   // entry at head, which is exactly where tail points when full.
   assign w_wr_acc = wrreq & (~w_full | w_rd_acc) & ~flush;

   // Pointers, level and error pulses
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_level    <= '0;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (flush) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_level    <= '0;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_tail <= r_tail + DEPTH_N'(1);
         end
         if (w_rd_acc) begin
            r_head <= r_head + DEPTH_N'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         r_underrun <= rdack & w_empty;
         r_overrun  <= wrreq & ~w_wr_acc;
      end
   end

   // Storage is deliberately not reset; level/pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_tail] <= wdata;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented combinationally; it becomes visible the
         // cycle after it is written because the level only then goes non-zero.
         assign rdata  = r_mem[r_head];
         assign rvalid = ~w_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] r_rdata;
         logic              r_rvalid;

         // Registered read: rvalid is a single-cycle pulse per pop and
         // rdata holds its last value in between.
         always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
               r_rdata  <= '0;
               r_rvalid <= 1'b0;
            end else if (flush) begin
               r_rvalid <= 1'b0;
            end else begin
               r_rvalid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rdata <= r_mem[r_head];
               end
            end
         end

         assign rdata  = r_rdata;
         assign rvalid = r_rvalid;
      end
   endgenerate

   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_level <= C_AEMPTY);
   assign almost_full  = (r_level >= C_AFULL);
   assign underrun     = r_underrun;
   assign overrun      = r_overrun;
   assign level        = r_level;

endmodule

// File: tb/tb_fifo_sync_buf.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_buf
//  Directed bench for fifo_sync_buf. Instance dut uses first-word-fall-through
//  (default parameters, DEPTH=16, AFULL=14, AEMPTY=1); instance dut_r uses the
//  registered read mode. Inputs change and outputs are sampled 1 ns after the
//  rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sync_buf;

   localparam int DATA_W = 8;
   localparam int DEPTH_N = 4;

   // clock / reset
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   // FWFT instance signals
   logic              flush = 1'b0;
   logic              wrreq = 1'b0;
   logic [DATA_W-1:0] wdata = '0;
   logic              rdack = 1'b0;
   logic [DATA_W-1:0] rdata;
   logic              rvalid, empty, full, almost_empty, almost_full;
   logic              underrun, overrun;
   logic [DEPTH_N:0]  level;

   // registered-read instance signals
   logic              r_flush = 1'b0;
   logic              r_wrreq = 1'b0;
   logic [DATA_W-1:0] r_wdata = '0;
   logic              r_rdack = 1'b0;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid, r_empty, r_full, r_almost_empty, r_almost_full;
   logic              r_underrun, r_overrun;
   logic [DEPTH_N:0]  r_level;

   fifo_sync_buf #(.DATA_W(DATA_W), .DEPTH_N(DEPTH_N), .FWFT(1'b1)) dut (
      .clk(clk), .n_reset(n_reset), .flush(flush), .wrreq(wrreq), .wdata(wdata),
      .rdack(rdack), .rdata(rdata), .rvalid(rvalid), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .underrun(underrun), .overrun(overrun), .level(level)
   );

   fifo_sync_buf #(.DATA_W(DATA_W), .DEPTH_N(DEPTH_N), .FWFT(1'b0)) dut_r (
      .clk(clk), .n_reset(n_reset), .flush(r_flush), .wrreq(r_wrreq), .wdata(r_wdata),
      .rdack(r_rdack), .rdata(r_rdata), .rvalid(r_rvalid), .empty(r_empty), .full(r_full),
      .almost_empty(r_almost_empty), .almost_full(r_almost_full),
      .underrun(r_underrun), .overrun(r_overrun), .level(r_level)
   );

   // scoreboard
   logic [DATA_W-1:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;
   int cnt     = 0;
   int k       = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      #2;
      check("rst_level", 32'(level), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_aempty", 32'(almost_empty), 1);
      check("rst_afull", 32'(almost_full), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_r_rvalid", 32'(r_rvalid), 0);
      check("rst_r_rdata", 32'(r_rdata), 0);
      tick();
      n_reset = 1'b1;
      tick();

      // ---------------- fill 0x00..0x0F ----------------
      for (int i = 0; i < 16; i++) begin
         wrreq = 1'b1;
         wdata = DATA_W'(i);
         exp_q.push_back(DATA_W'(i));
         tick();
         check("fill_level", 32'(level), 32'(i + 1));
         check("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
         check("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 1));
         check("fill_full", 32'(full), 32'((i + 1) == 16));
      end
      check("fill_head", 32'(rdata), 32'h00);
      check("fill_rvalid", 32'(rvalid), 1);

      // ---------------- write while full, no pop ----------------
      wrreq = 1'b1;
      wdata = 8'h10;
      tick();
      wrreq = 1'b0;
      check("ovr_pulse", 32'(overrun), 1);
      check("ovr_level", 32'(level), 16);
      tick();
      check("ovr_clear", 32'(overrun), 0);
      check("ovr_head", 32'(rdata), 32'h00);

      // ---------------- write + pop while full ----------------
      check("fullrw_rdata", 32'(rdata), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      wrreq = 1'b1;
      rdack = 1'b1;
      wdata = 8'hAA;
      exp_q.push_back(8'hAA);
      tick();
      wrreq = 1'b0;
      rdack = 1'b0;
      check("fullrw_level", 32'(level), 16);
      check("fullrw_ovr", 32'(overrun), 0);
      check("fullrw_head", 32'(rdata), 32'h01);

      // ---------------- drain 16 ----------------
      for (int i = 0; i < 16; i++) begin
         check("drain_rdata", 32'(rdata), 32'(exp_q[0]));
         void'(exp_q.pop_front());
         rdack = 1'b1;
         tick();
         check("drain_level", 32'(level), 32'(15 - i));
      end
      check("drain_empty", 32'(empty), 1);
      check("drain_rvalid", 32'(rvalid), 0);
      check("drain_underrun_pre", 32'(underrun), 0);
      tick();   // rdack still high on empty
      rdack = 1'b0;
      check("udr_pulse", 32'(underrun), 1);
      check("udr_level", 32'(level), 0);
      check("udr_empty", 32'(empty), 1);
      tick();
      check("udr_clear", 32'(underrun), 0);

      // ---------------- empty + write + pop: no bypass ----------------
      wrreq = 1'b1;
      rdack = 1'b1;
      wdata = 8'h3C;
      exp_q.push_back(8'h3C);
      tick();
      wrreq = 1'b0;
      rdack = 1'b0;
      check("nobyp_level", 32'(level), 1);
      check("nobyp_udr", 32'(underrun), 1);
      check("nobyp_rdata", 32'(rdata), 32'h3C);
      cnt = 1;

      // ---------------- pointer wrap, level held in 3..5 ----------------
      k = 0;
      while (cnt < 4) begin
         wrreq = 1'b1;
         wdata = DATA_W'(8'h40 + k);
         exp_q.push_back(wdata);
         k++;
         tick();
         cnt++;
      end
      wrreq = 1'b0;
      check("wrap_pre_level", 32'(level), 4);
      for (int c = 0; c < 40; c++) begin
         logic do_wr, do_rd;
         if (cnt <= 3) begin
            do_wr = 1'b1; do_rd = 1'b0;
         end else if (cnt >= 5) begin
            do_wr = 1'b0; do_rd = 1'b1;
         end else begin
            do_wr = (c % 3) != 2;
            do_rd = (c % 3) != 1;
         end
         if (do_rd) begin
            check("wrap_rdata", 32'(rdata), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         if (do_wr) begin
            wdata = DATA_W'(8'h40 + k);
            exp_q.push_back(wdata);
            k++;
         end
         wrreq = do_wr;
         rdack = do_rd;
         tick();
         cnt = cnt + int'(do_wr) - int'(do_rd);
         check("wrap_level", 32'(level), 32'(cnt));
      end
      wrreq = 1'b0;
      rdack = 1'b0;

      // ---------------- flush at level 9 with wrreq ----------------
      while (cnt < 9) begin
         wrreq = 1'b1;
         wdata = DATA_W'(8'h40 + k);
         k++;
         tick();
         cnt++;
      end
      check("flush_pre_level", 32'(level), 9);
      flush = 1'b1;
      wrreq = 1'b1;
      wdata = 8'hEE;
      tick();
      flush = 1'b0;
      wrreq = 1'b0;
      exp_q.delete();
      cnt = 0;
      check("flush_level", 32'(level), 0);
      check("flush_empty", 32'(empty), 1);
      check("flush_ovr", 32'(overrun), 0);
      check("flush_rvalid", 32'(rvalid), 0);
      tick();
      check("flush_level2", 32'(level), 0);
      wrreq = 1'b1;
      wdata = 8'h77;
      tick();
      wrreq = 1'b0;
      check("postflush_rdata", 32'(rdata), 32'h77);
      check("postflush_level", 32'(level), 1);

      // ---------------- registered read mode ----------------
      r_wrreq = 1'b1;
      r_wdata = 8'h5A;
      tick();
      r_wrreq = 1'b0;
      check("reg_rvalid_idle", 32'(r_rvalid), 0);
      check("reg_level", 32'(r_level), 1);
      r_rdack = 1'b1;
      tick();
      r_rdack = 1'b0;
      check("reg_rvalid", 32'(r_rvalid), 1);
      check("reg_rdata", 32'(r_rdata), 32'h5A);
      check("reg_empty", 32'(r_empty), 1);
      tick();
      check("reg_rvalid_drop", 32'(r_rvalid), 0);
      check("reg_rdata_hold", 32'(r_rdata), 32'h5A);

      // ---------------- async reset mid-transfer ----------------
      wrreq = 1'b1;
      wdata = 8'h12;
      tick();
      wrreq = 1'b0;
      check("midrst_pre_level", 32'(level), 2);
      #2;
      n_reset = 1'b0;
      #1;
      check("midrst_level", 32'(level), 0);
      check("midrst_empty", 32'(empty), 1);
      check("midrst_rvalid", 32'(rvalid), 0);
      check("midrst_r_rdata", 32'(r_rdata), 0);
      tick();
      n_reset = 1'b1;
      tick();
      check("midrst_after_level", 32'(level), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
